// File: rtl/lcd_cmd_seq.sv
// Command sequencer in front of the LCD image controller: buffers host opcodes,
// drops illegal ones, and issues one command per controller busy cycle until a Write completes.
module lcd_cmd_seq #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] in_cmd,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       lcd_busy,
  input  logic       lcd_done,
  output logic [3:0] lcd_cmd,
  output logic       lcd_cmd_valid,
  output logic [7:0] issued_cnt,
  output logic [3:0] illegal_cnt,
  output logic       seq_done
);

  typedef enum logic [1:0] {WAIT_RDY, HOLD, FLUSH, DONE} state_e;

  state_e        state_q, state_d;
  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic [3:0]    cmd_q, cmd_d;
  logic          vld_q, vld_d;
  logic [7:0]    issued_q, issued_d;
  logic [3:0]    illegal_q, illegal_d;

  logic       full, empty, accept, bad, push, pop, pop_wr;
  logic [3:0] head;

  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign in_ready = !full && (state_q == WAIT_RDY || state_q == HOLD);
  assign accept   = in_valid && in_ready;
  assign bad      = (in_cmd >= 4'hC);
  assign push     = accept && !bad;
  assign head     = mem_q[rd_q];
  assign pop      = (state_q == WAIT_RDY) && !lcd_busy && !empty;
  // Issuing a Write ends the run: whatever is still queued is dropped.
  assign pop_wr   = pop && (head == 4'h0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_RDY: if (pop) state_d = pop_wr ? FLUSH : HOLD;
      HOLD:     if (lcd_busy) state_d = WAIT_RDY;
      FLUSH:    if (lcd_done) state_d = DONE;
      DONE:     state_d = DONE;
      default:  state_d = WAIT_RDY;
    endcase
  end

  always_comb begin
    cmd_d     = cmd_q;
    vld_d     = pop;
    issued_d  = issued_q;
    illegal_d = illegal_q;
    if (pop) begin
      cmd_d = head;
      if (issued_q != 8'hFF) issued_d = issued_q + 8'd1;
    end
    if (accept && bad && illegal_q != 4'hF) illegal_d = illegal_q + 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= WAIT_RDY;
      cmd_q     <= '0;
      vld_q     <= 1'b0;
      issued_q  <= '0;
      illegal_q <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      vld_q     <= vld_d;
      issued_q  <= issued_d;
      illegal_q <= illegal_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (pop_wr) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= in_cmd;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign lcd_cmd       = cmd_q;
  assign lcd_cmd_valid = vld_q;
  assign issued_cnt    = issued_q;
  assign illegal_cnt   = illegal_q;
  assign seq_done      = (state_q == DONE);

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Bench for lcd_cmd_seq: a queue-based model of the sequencer plus a simple
// controller busy model; every cycle the DUT outputs are compared to the model.
module tb_lcd_cmd_seq;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_cmd;
  logic       in_valid, in_ready, lcd_busy, lcd_done;
  logic [3:0] lcd_cmd;
  logic       lcd_cmd_valid;
  logic [7:0] issued_cnt;
  logic [3:0] illegal_cnt;
  logic       seq_done;

  always #5 clk = ~clk;

  lcd_cmd_seq #(.DEPTH(8), .AW(3)) dut (
    .clk(clk), .reset(reset), .in_cmd(in_cmd), .in_valid(in_valid), .in_ready(in_ready),
    .lcd_busy(lcd_busy), .lcd_done(lcd_done), .lcd_cmd(lcd_cmd), .lcd_cmd_valid(lcd_cmd_valid),
    .issued_cnt(issued_cnt), .illegal_cnt(illegal_cnt), .seq_done(seq_done)
  );

  // model: phase 0 = may issue, 1 = waiting for busy ack, 2 = write issued, 3 = finished
  logic [3:0] m_q[$];
  int         m_phase, m_issued, m_illegal;
  logic [3:0] m_cmd;
  logic       m_valid;
  int         checks = 0, errors = 0;
  logic       busy_force;
  int         bcnt;

  function automatic logic [18:0] obs();
    return {in_ready, lcd_cmd_valid, lcd_cmd, issued_cnt, illegal_cnt, seq_done};
  endfunction

  function automatic logic [18:0] expv();
    logic rdy;
    rdy = (m_q.size() < DEPTH) && (m_phase < 2);
    return {rdy, m_valid, m_cmd, 8'(m_issued), 4'(m_illegal), (m_phase == 3)};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_phase = 0; m_issued = 0; m_illegal = 0; m_cmd = '0; m_valid = 1'b0;
  endtask

  // Drive one cycle of inputs (controller busy rises the cycle after a pulse,
  // for two cycles), advance the model, and land on the next falling edge.
  task automatic step(input logic v, input logic [3:0] c, input logic d);
    logic       rdy, pop;
    logic [3:0] head;
    in_valid = v; in_cmd = c; lcd_done = d;
    lcd_busy = busy_force || (bcnt > 0);
    if (m_valid) bcnt = 2; else if (bcnt > 0) bcnt--;
    rdy  = (m_q.size() < DEPTH) && (m_phase < 2);
    pop  = (m_phase == 0) && !lcd_busy && (m_q.size() > 0);
    head = '0;
    m_valid = 1'b0;
    if (pop) begin
      head = m_q.pop_front();
      m_cmd = head; m_valid = 1'b1;
      if (m_issued < 255) m_issued++;
      m_phase = (head == 4'h0) ? 2 : 1;
    end else if (m_phase == 1 && lcd_busy) m_phase = 0;
    else if (m_phase == 2 && d) m_phase = 3;
    if (v && rdy) begin
      if (c >= 4'hC) begin
        if (m_illegal < 15) m_illegal++;
      end else if (!(pop && head == 4'h0)) m_q.push_back(c);
    end
    if (pop && head == 4'h0) m_q.delete();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1; in_valid = 1'b0; in_cmd = '0; lcd_done = 1'b0;
    busy_force = 1'b1; lcd_busy = 1'b1; bcnt = 0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_cmd = '0; lcd_done = 1'b0;
    busy_force = 1'b1; lcd_busy = 1'b1; bcnt = 0;
    model_reset();
    @(negedge clk);
    if (obs() !== 19'h40000) begin
      errors++; $display("FAIL reset_values: got %h want %h", obs(), 19'h40000);
    end
    checks++;
    reset = 1'b0;
    step(1'b0, 4'h0, 1'b0);
    if (obs() !== expv()) begin
      errors++; $display("FAIL after_reset: got %h want %h", obs(), expv());
    end
    checks++;
  endtask

  task automatic test_idle_busy();
    apply_reset();
    for (int i = 0; i < 70; i++) begin
      step(i == 3 || i == 10 || i == 20, (i == 3) ? 4'h1 : (i == 10) ? 4'h5 : 4'h9, 1'b0);
      if (obs() !== expv()) begin
        errors++; $display("FAIL idle_busy cyc %0d: got %h want %h", i, obs(), expv());
      end
      checks++;
    end
    if (issued_cnt !== 8'd0 || m_q.size() != 3) begin
      errors++; $display("FAIL idle_no_issue: issued %0d queued %0d want 0/3", issued_cnt, m_q.size());
    end
    checks++;
    busy_force = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 4'h0, 1'b0);
      if (obs() !== expv()) begin
        errors++; $display("FAIL idle_drain cyc %0d: got %h want %h", i, obs(), expv());
      end
      checks++;
    end
    if (issued_cnt !== 8'd3 || lcd_cmd !== 4'h9) begin
      errors++; $display("FAIL idle_drain_end: issued %0d cmd %h want 3/9", issued_cnt, lcd_cmd);
    end
    checks++;
  endtask

  task automatic test_paced();
    int         pcyc[$];
    logic [3:0] pcmd[$];
    apply_reset();
    busy_force = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(i < 3, (i == 0) ? 4'h3 : (i == 1) ? 4'h7 : 4'h8, 1'b0);
      if (obs() !== expv()) begin
        errors++; $display("FAIL paced cyc %0d: got %h want %h", i, obs(), expv());
      end
      checks++;
      if (lcd_cmd_valid === 1'b1) begin pcyc.push_back(i); pcmd.push_back(lcd_cmd); end
    end
    if (pcyc.size() != 3) begin
      errors++; $display("FAIL paced_count: got %0d want 3", pcyc.size());
    end else begin
      if (pcyc[0] != 1) begin
        errors++; $display("FAIL paced_latency: got cycle %0d want 1", pcyc[0]);
      end
      if (pcmd[0] !== 4'h3 || pcmd[1] !== 4'h7 || pcmd[2] !== 4'h8) begin
        errors++; $display("FAIL paced_order: got %h %h %h want 3 7 8", pcmd[0], pcmd[1], pcmd[2]);
      end
      if (pcyc[1] - pcyc[0] < 3 || pcyc[2] - pcyc[1] < 3) begin
        errors++; $display("FAIL paced_gap: got %0d %0d want >=3", pcyc[1] - pcyc[0], pcyc[2] - pcyc[1]);
      end
    end
    checks++;
    if (issued_cnt !== 8'd3) begin
      errors++; $display("FAIL paced_issued: got %0d want 3", issued_cnt);
    end
    checks++;
  endtask

  task automatic test_illegal();
    apply_reset();
    busy_force = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i < 3 && in_ready !== 1'b1) begin
        errors++; $display("FAIL illegal_ready cyc %0d: got %b want 1", i, in_ready);
      end
      if (i < 3) checks++;
      step(i < 3, (i == 0) ? 4'hC : (i == 1) ? 4'h2 : 4'hF, 1'b0);
      if (obs() !== expv()) begin
        errors++; $display("FAIL illegal cyc %0d: got %h want %h", i, obs(), expv());
      end
      checks++;
    end
    if (illegal_cnt !== 4'd2 || issued_cnt !== 8'd1 || lcd_cmd !== 4'h2) begin
      errors++; $display("FAIL illegal_end: ill %0d iss %0d cmd %h want 2/1/2", illegal_cnt, issued_cnt, lcd_cmd);
    end
    checks++;
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      if (i == 8 && in_ready !== 1'b0) begin
        errors++; $display("FAIL full_ready_low: got %b want 0", in_ready);
      end
      if (i == 8) checks++;
      step(1'b1, 4'(i + 1), 1'b0);
      if (obs() !== expv()) begin
        errors++; $display("FAIL full cyc %0d: got %h want %h", i, obs(), expv());
      end
      checks++;
    end
    busy_force = 1'b0;
    step(1'b0, 4'h0, 1'b0);
    if (in_ready !== 1'b1 || lcd_cmd_valid !== 1'b1 || lcd_cmd !== 4'h1) begin
      errors++; $display("FAIL full_pop: ready %b vld %b cmd %h want 1/1/1", in_ready, lcd_cmd_valid, lcd_cmd);
    end
    checks++;
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 4'h0, 1'b0);
      if (obs() !== expv()) begin
        errors++; $display("FAIL full_drain cyc %0d: got %h want %h", i, obs(), expv());
      end
      checks++;
    end
    if (issued_cnt !== 8'd8 || lcd_cmd !== 4'h8) begin
      errors++; $display("FAIL full_end: issued %0d cmd %h want 8/8", issued_cnt, lcd_cmd);
    end
    checks++;
  endtask

  task automatic test_write();
    int n;
    apply_reset();
    busy_force = 1'b0;
    n = 0;
    while (m_phase != 2 && n < 60) begin
      step(n < 3, (n == 0) ? 4'h4 : (n == 1) ? 4'h0 : 4'h1, 1'b0);
      if (obs() !== expv()) begin
        errors++; $display("FAIL write cyc %0d: got %h want %h", n, obs(), expv());
      end
      checks++;
      n++;
    end
    if (m_phase != 2 || in_ready !== 1'b0 || lcd_cmd !== 4'h0) begin
      errors++; $display("FAIL write_issue: ready %b cmd %h after %0d cycles want 0/0", in_ready, lcd_cmd, n);
    end
    checks++;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'h5, i == 4);
      if (obs() !== expv()) begin
        errors++; $display("FAIL write_wait cyc %0d: got %h want %h", i, obs(), expv());
      end
      checks++;
    end
    if (seq_done !== 1'b1) begin
      errors++; $display("FAIL write_done_rise: got %b want 1", seq_done);
    end
    checks++;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 4'($urandom_range(1, 11)), 1'($urandom_range(0, 1)));
      if (obs() !== expv()) begin
        errors++; $display("FAIL write_after cyc %0d: got %h want %h", i, obs(), expv());
      end
      checks++;
    end
    if (issued_cnt !== 8'd2 || seq_done !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL write_end: iss %0d done %b ready %b want 2/1/0", issued_cnt, seq_done, in_ready);
    end
    checks++;
  endtask

  task automatic test_midrun_reset();
    apply_reset();
    busy_force = 1'b0;
    step(1'b1, 4'h6, 1'b0);
    in_valid = 1'b0; lcd_busy = 1'b0;
    @(posedge clk);
    #1;
    if (lcd_cmd_valid !== 1'b1 || lcd_cmd !== 4'h6) begin
      errors++; $display("FAIL midrun_issue: vld %b cmd %h want 1/6", lcd_cmd_valid, lcd_cmd);
    end
    checks++;
    reset = 1'b1;
    #1;
    model_reset();
    if (obs() !== 19'h40000) begin
      errors++; $display("FAIL midrun_reset: got %h want %h", obs(), 19'h40000);
    end
    checks++;
    @(negedge clk);
    reset = 1'b0; bcnt = 0; busy_force = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 4'h0, 1'b0);
      if (obs() !== expv()) begin
        errors++; $display("FAIL midrun_empty cyc %0d: got %h want %h", i, obs(), expv());
      end
      checks++;
    end
  endtask

  task automatic test_saturate();
    apply_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 4'($urandom_range(12, 15)), 1'b0);
    if (illegal_cnt !== 4'd15) begin
      errors++; $display("FAIL illegal_sat: got %0d want 15", illegal_cnt);
    end
    checks++;
    busy_force = 1'b0;
    for (int i = 0; i < 1300; i++) begin
      step(1'b1, 4'($urandom_range(1, 15)), 1'b0);
      if (obs() !== expv()) begin
        errors++; $display("FAIL sat cyc %0d: got %h want %h", i, obs(), expv());
      end
      checks++;
    end
    if (issued_cnt !== 8'd255 || illegal_cnt !== 4'd15) begin
      errors++; $display("FAIL issued_sat: iss %0d ill %0d want 255/15", issued_cnt, illegal_cnt);
    end
    checks++;
  endtask

  task automatic test_random();
    logic [3:0] c;
    for (int r = 0; r < 3; r++) begin
      apply_reset();
      busy_force = 1'b0;
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, 19) == 0) busy_force = ~busy_force;
        c = ($urandom_range(0, 49) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        step(1'($urandom_range(0, 1)), c, $urandom_range(0, 7) == 0);
        if (obs() !== expv()) begin
          errors++; $display("FAIL random r%0d cyc %0d: got %h want %h", r, i, obs(), expv());
        end
        checks++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_busy();
    test_paced();
    test_illegal();
    test_full();
    test_write();
    test_midrun_reset();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
